// File: rtl/lvt_pkg.sv
// Shared load-value-table types: entry layout and confidence encoding.
// Tag field is sized for the smallest legal index so any INDEX_WIDTH fits; unused upper bits stay zero.
package lvt_pkg;

  localparam int ADDR_WIDTH    = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int CONF_WIDTH    = 2;
  localparam int CONF_MAX      = 3;
  localparam int TAG_WIDTH_MAX = ADDR_WIDTH - 2;

  typedef struct packed {
    logic                     valid;
    logic [TAG_WIDTH_MAX-1:0] tag;
    logic [DATA_WIDTH-1:0]    value;
    logic [CONF_WIDTH-1:0]    conf;
  } lvt_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment); holds at all-ones.
// Used for per-entry confidence and for the 16-bit statistics counters.
module sat_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/load_value_table.sv
// Direct-mapped load value predictor: lookup result one cycle after lu_valid, trained by committed loads.
// One lookup and one train accepted every cycle; never stalls. Lookups see pre-train contents.
module load_value_table
  import lvt_pkg::*;
#(
  parameter int INDEX_WIDTH = 6,
  parameter int CONF_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lu_valid,
  input  logic [ADDR_WIDTH-1:0] lu_pc,
  input  logic                  tr_valid,
  input  logic [ADDR_WIDTH-1:0] tr_pc,
  input  logic [DATA_WIDTH-1:0] tr_value,
  input  logic                  flush,
  output logic                  pred_valid,
  output logic                  pred_hit,
  output logic                  pred_confident,
  output logic [DATA_WIDTH-1:0] pred_value,
  output logic [15:0]           stat_lookups,
  output logic [15:0]           stat_confident
);

  localparam int ENTRIES   = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_WIDTH-1:0]  tag_q   [ENTRIES];
  logic [DATA_WIDTH-1:0] value_q [ENTRIES];
  logic [CONF_WIDTH-1:0] conf    [ENTRIES];

  logic [INDEX_WIDTH-1:0] lu_idx, tr_idx;
  logic [TAG_WIDTH-1:0]   lu_tag, tr_tag;
  logic                   unused_pc_lsbs;

  assign lu_idx = lu_pc[INDEX_WIDTH+1:2];
  assign tr_idx = tr_pc[INDEX_WIDTH+1:2];
  assign lu_tag = lu_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign tr_tag = tr_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign unused_pc_lsbs = ^{lu_pc[1:0], tr_pc[1:0]};

  lvt_entry_t lu_entry;
  logic       lu_hit, tr_hit, tr_same;

  always_comb begin
    lu_entry       = '0;
    lu_entry.valid = valid_q[lu_idx];
    lu_entry.tag   = TAG_WIDTH_MAX'(tag_q[lu_idx]);
    lu_entry.value = value_q[lu_idx];
    lu_entry.conf  = conf[lu_idx];
  end

  assign lu_hit  = lu_entry.valid && (lu_entry.tag == TAG_WIDTH_MAX'(lu_tag));
  assign tr_hit  = valid_q[tr_idx] && (tag_q[tr_idx] == tr_tag);
  assign tr_same = tr_hit && (value_q[tr_idx] == tr_value);

  // Flush clears every counter and, via clear priority, overrides a same-cycle increment.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_conf
    logic sel;
    assign sel = tr_valid && (tr_idx == INDEX_WIDTH'(i));
    sat_counter #(.WIDTH(CONF_WIDTH)) u_conf (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (sel && tr_same),
      .clr   (flush || (sel && !tr_same)),
      .count (conf[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (tr_valid) begin
      valid_q[tr_idx] <= 1'b1;
    end
  end

  // Tag/value need no reset: they are only observed behind valid.
  always_ff @(posedge clk) begin
    if (tr_valid) begin
      tag_q[tr_idx]   <= tr_tag;
      value_q[tr_idx] <= tr_value;
    end
  end

  logic                  pred_valid_q, pred_valid_d;
  logic                  pred_hit_q, pred_hit_d;
  logic                  pred_conf_q, pred_conf_d;
  logic [DATA_WIDTH-1:0] pred_value_q, pred_value_d;

  always_comb begin
    pred_valid_d = lu_valid;
    pred_hit_d   = lu_valid && lu_hit;
    pred_conf_d  = pred_hit_d && !flush &&
                   (lu_entry.conf >= CONF_WIDTH'(CONF_THRESH));
    pred_value_d = pred_hit_d ? lu_entry.value : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q <= 1'b0;
      pred_hit_q   <= 1'b0;
      pred_conf_q  <= 1'b0;
      pred_value_q <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_hit_q   <= pred_hit_d;
      pred_conf_q  <= pred_conf_d;
      pred_value_q <= pred_value_d;
    end
  end

  assign pred_valid     = pred_valid_q;
  assign pred_hit       = pred_hit_q;
  assign pred_confident = pred_conf_q;
  assign pred_value     = pred_value_q;

  sat_counter #(.WIDTH(16)) u_stat_lookups (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (lu_valid),
    .clr   (1'b0),
    .count (stat_lookups)
  );

  sat_counter #(.WIDTH(16)) u_stat_confident (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pred_conf_q),
    .clr   (1'b0),
    .count (stat_confident)
  );

endmodule

// File: tb/tb_load_value_table.sv
// Directed table-driven bench for load_value_table plus hand-written reset and saturation sequences.
module tb_load_value_table;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lu_valid;
  logic [31:0] lu_pc;
  logic        tr_valid;
  logic [31:0] tr_pc;
  logic [31:0] tr_value;
  logic        flush;
  logic        pred_valid, pred_hit, pred_confident;
  logic [31:0] pred_value;
  logic [15:0] stat_lookups, stat_confident;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_value_table dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lu_valid       (lu_valid),
    .lu_pc          (lu_pc),
    .tr_valid       (tr_valid),
    .tr_pc          (tr_pc),
    .tr_value       (tr_value),
    .flush          (flush),
    .pred_valid     (pred_valid),
    .pred_hit       (pred_hit),
    .pred_confident (pred_confident),
    .pred_value     (pred_value),
    .stat_lookups   (stat_lookups),
    .stat_confident (stat_confident)
  );

  typedef struct {
    logic        lu_v;
    logic [31:0] lu_pc;
    logic        tr_v;
    logic [31:0] tr_pc;
    logic [31:0] tr_val;
    logic        fl;
    logic        e_valid;
    logic        e_hit;
    logic        e_conf;
    logic [31:0] e_value;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] PC_A = 32'h0040_0010;
  localparam logic [31:0] PC_B = 32'h0040_1010;
  localparam logic [31:0] PC_C = 32'h0040_0020;
  localparam logic [31:0] PC_D = 32'h0000_00FC;
  localparam logic [31:0] PC_Z = 32'h0000_0000;

  task automatic add(input logic lv, input logic [31:0] lpc, input logic tv,
                     input logic [31:0] tpc, input logic [31:0] tval, input logic fl,
                     input logic ev, input logic eh, input logic ec, input logic [31:0] eval);
    vec_t v;
    v.lu_v = lv; v.lu_pc = lpc; v.tr_v = tv; v.tr_pc = tpc; v.tr_val = tval; v.fl = fl;
    v.e_valid = ev; v.e_hit = eh; v.e_conf = ec; v.e_value = eval;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    lu_valid = 1'b0; lu_pc = '0; tr_valid = 1'b0; tr_pc = '0; tr_value = '0; flush = 1'b0;
  endtask

  initial begin
    int exp_lookups;
    int exp_conf;
    exp_lookups = 0;
    exp_conf    = 0;

    //  lu  lu_pc                  tr  tr_pc  tr_val        fl  valid hit conf value
    add(1, PC_A,           0, PC_Z, 32'h0,    0,  1, 0, 0, 32'h0);     // cold miss
    add(1, PC_Z,           0, PC_Z, 32'h0,    0,  1, 0, 0, 32'h0);     // tag 0 but invalid
    add(0, PC_Z,           1, PC_A, 32'h1234, 0,  0, 0, 0, 32'h0);
    add(0, PC_Z,           1, PC_A, 32'h1234, 0,  0, 0, 0, 32'h0);
    add(0, PC_Z,           1, PC_A, 32'h1234, 0,  0, 0, 0, 32'h0);
    add(1, PC_A,           0, PC_Z, 32'h0,    0,  1, 1, 1, 32'h1234);  // conf 2
    add(0, PC_Z,           1, PC_A, 32'h5678, 0,  0, 0, 0, 32'h0);
    add(1, PC_A,           0, PC_Z, 32'h0,    0,  1, 1, 0, 32'h5678);
    add(1, 32'h0040_0013,  0, PC_Z, 32'h0,    0,  1, 1, 0, 32'h5678);  // pc[1:0] ignored
    add(0, PC_Z,           1, PC_B, 32'hBEEF, 0,  0, 0, 0, 32'h0);     // alias evicts A
    add(1, PC_A,           0, PC_Z, 32'h0,    0,  1, 0, 0, 32'h0);
    add(1, PC_B,           0, PC_Z, 32'h0,    0,  1, 1, 0, 32'hBEEF);
    add(0, PC_Z,           1, PC_B, 32'hBEEF, 0,  0, 0, 0, 32'h0);
    add(0, PC_Z,           1, PC_B, 32'hBEEF, 0,  0, 0, 0, 32'h0);
    add(0, PC_Z,           1, PC_C, 32'h77,   0,  0, 0, 0, 32'h0);
    add(0, PC_Z,           1, PC_C, 32'h77,   0,  0, 0, 0, 32'h0);
    add(0, PC_Z,           1, PC_C, 32'h77,   0,  0, 0, 0, 32'h0);
    add(1, PC_C,           0, PC_Z, 32'h0,    0,  1, 1, 1, 32'h77);
    add(1, PC_B,           0, PC_Z, 32'h0,    0,  1, 1, 1, 32'hBEEF);
    add(1, PC_B,           1, PC_B, 32'hCAFE, 1,  1, 1, 0, 32'hBEEF);  // lookup+train+flush
    add(1, PC_B,           0, PC_Z, 32'h0,    0,  1, 1, 0, 32'hCAFE);
    add(1, PC_C,           0, PC_Z, 32'h0,    0,  1, 1, 0, 32'h77);    // flushed elsewhere too
    add(1, PC_C,           1, PC_C, 32'h88,   0,  1, 1, 0, 32'h77);    // read-before-write
    add(1, PC_C,           0, PC_Z, 32'h0,    0,  1, 1, 0, 32'h88);
    add(0, PC_Z,           1, PC_C, 32'h88,   0,  0, 0, 0, 32'h0);
    add(0, PC_Z,           1, PC_C, 32'h88,   0,  0, 0, 0, 32'h0);
    add(0, PC_Z,           1, PC_C, 32'h88,   0,  0, 0, 0, 32'h0);
    add(0, PC_Z,           1, PC_C, 32'h88,   0,  0, 0, 0, 32'h0);     // would wrap without saturation
    add(1, PC_C,           0, PC_Z, 32'h0,    0,  1, 1, 1, 32'h88);
    add(0, PC_Z,           1, PC_D, 32'h1,    0,  0, 0, 0, 32'h0);
    add(0, PC_Z,           1, PC_D, 32'h1,    0,  0, 0, 0, 32'h0);
    add(1, PC_D,           0, PC_Z, 32'h0,    0,  1, 1, 0, 32'h1);     // conf 1 < threshold
    add(0, PC_Z,           1, PC_D, 32'h1,    0,  0, 0, 0, 32'h0);
    add(1, PC_D,           0, PC_Z, 32'h0,    0,  1, 1, 1, 32'h1);     // conf 2 == threshold
    add(0, PC_Z,           0, PC_Z, 32'h0,    0,  0, 0, 0, 32'h0);

    rst_n = 1'b0;
    idle_inputs();
    #3;
    check("reset pred_valid", {31'b0, pred_valid}, 32'd0);
    check("reset pred_hit", {31'b0, pred_hit}, 32'd0);
    check("reset pred_confident", {31'b0, pred_confident}, 32'd0);
    check("reset stat_lookups", {16'b0, stat_lookups}, 32'd0);
    check("reset stat_confident", {16'b0, stat_confident}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      lu_valid = vecs[i].lu_v;  lu_pc = vecs[i].lu_pc;
      tr_valid = vecs[i].tr_v;  tr_pc = vecs[i].tr_pc;
      tr_value = vecs[i].tr_val; flush = vecs[i].fl;
      if (vecs[i].lu_v) exp_lookups++;
      if (vecs[i].e_conf) exp_conf++;
      @(posedge clk); #1;
      check($sformatf("v%0d pred_valid", i), {31'b0, pred_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d pred_hit", i), {31'b0, pred_hit}, {31'b0, vecs[i].e_hit});
      check($sformatf("v%0d pred_confident", i), {31'b0, pred_confident}, {31'b0, vecs[i].e_conf});
      check($sformatf("v%0d pred_value", i), pred_value, vecs[i].e_value);
    end
    idle_inputs();
    @(posedge clk); #1;
    check("stat_lookups after table", {16'b0, stat_lookups}, exp_lookups);
    check("stat_confident after table", {16'b0, stat_confident}, exp_conf);

    // Saturate stat_lookups with back-to-back misses on the evicted PC.
    lu_valid = 1'b1; lu_pc = PC_A;
    repeat (65536) @(posedge clk);
    #1;
    check("sat run pred_hit", {31'b0, pred_hit}, 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    check("stat_lookups saturated", {16'b0, stat_lookups}, 32'h0000_FFFF);
    check("stat_confident held", {16'b0, stat_confident}, exp_conf);

    // Reset lands while a lookup is in flight.
    lu_valid = 1'b1; lu_pc = PC_B;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset pred_valid", {31'b0, pred_valid}, 32'd0);
    check("midreset stat_lookups", {16'b0, stat_lookups}, 32'd0);
    check("midreset stat_confident", {16'b0, stat_confident}, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postreset idle pred_valid", {31'b0, pred_valid}, 32'd0);
    lu_valid = 1'b1; lu_pc = PC_B;
    @(posedge clk); #1;
    idle_inputs();
    check("postreset lookup pred_valid", {31'b0, pred_valid}, 32'd1);
    check("postreset lookup pred_hit", {31'b0, pred_hit}, 32'd0);
    check("postreset lookup pred_value", pred_value, 32'd0);
    @(posedge clk); #1;
    check("postreset stat_lookups", {16'b0, stat_lookups}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
